// File: rtl/bf16_pkg.sv
// Shared constants and types for the BFloat16 multiplier scheduler.
package bf16_pkg;

    localparam int unsigned EXP_W     = 8;
    localparam int unsigned MAN_W     = 7;
    localparam int unsigned BF16_BIAS = 127;
    localparam int unsigned CNT_W     = 4;

    localparam logic [15:0]      BF16_QNAN    = 16'h7FC0;
    localparam logic [EXP_W-1:0] BF16_EXP_INF = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

endpackage

// File: rtl/bf16_mul_core.sv
// Combinational BFloat16 multiply: truncating, subnormals flushed, inf/NaN collapsed to QNaN.
module bf16_mul_core
    import bf16_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] p
);

    logic              sign;
    logic [EXP_W-1:0]  ea;
    logic [EXP_W-1:0]  eb;
    logic [MAN_W:0]    sig_a;
    logic [MAN_W:0]    sig_b;
    logic [15:0]       prod;
    logic              norm;
    logic [MAN_W-1:0]  man;
    logic [9:0]        exp_sum;
    logic signed [9:0] exp_s;

    always_comb begin
        sign    = a[15] ^ b[15];
        ea      = a[14:7];
        eb      = b[14:7];
        sig_a   = {1'b1, a[6:0]};
        sig_b   = {1'b1, b[6:0]};
        prod    = 16'(sig_a) * 16'(sig_b);
        norm    = prod[15];
        man     = norm ? prod[14:8] : prod[13:7];
        exp_sum = 10'(ea) + 10'(eb) + 10'(norm) - 10'(BF16_BIAS);
        exp_s   = $signed(exp_sum);

        // Zero operands take priority over inf/NaN operands.
        if (ea == '0 || eb == '0) begin
            p = {sign, 15'b0};
        end else if (ea == BF16_EXP_INF || eb == BF16_EXP_INF) begin
            p = BF16_QNAN;
        end else if (exp_s <= 10'sd0) begin
            p = {sign, 15'b0};
        end else if (exp_s >= 10'sd255) begin
            p = {sign, BF16_EXP_INF, 7'b0};
        end else begin
            p = {sign, exp_s[7:0], man};
        end
    end

endmodule

// File: rtl/bf16_mul_sched.sv
// Round-robin scheduler sharing one multicycle BFloat16 multiplier among NREQ requesters.
module bf16_mul_sched
    import bf16_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2,
    parameter int unsigned LAT  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [16*NREQ-1:0] req_a,
    input  logic [16*NREQ-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [15:0]       rsp_data,
    output logic              busy
);

    state_t           state;
    logic [IDW-1:0]   rr_ptr;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      op_a;
    logic [15:0]      op_b;
    logic [IDW-1:0]   id_q;
    logic [15:0]      data_q;
    logic [15:0]      core_p;

    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   grant_idx;
    logic [IDW-1:0]   next_ptr;
    logic [15:0]      sel_a;
    logic [15:0]      sel_b;
    logic             found;
    logic [IDW:0]     pos;

    // Search upward from rr_ptr with wrap; first pending requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (pos >= (IDW+1)'(NREQ)) begin
                pos = pos - (IDW+1)'(NREQ);
            end
            if (!found && req_valid[pos[IDW-1:0]]) begin
                found                 = 1'b1;
                grant[pos[IDW-1:0]]   = 1'b1;
                grant_idx             = pos[IDW-1:0];
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a = req_a[16*i +: 16];
                sel_b = req_b[16*i +: 16];
            end
        end
    end

    assign next_ptr = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

    bf16_mul_core u_core (
        .a (op_a),
        .b (op_b),
        .p (core_p)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            cnt    <= '0;
            op_a   <= '0;
            op_b   <= '0;
            id_q   <= '0;
            data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        op_a   <= sel_a;
                        op_b   <= sel_b;
                        id_q   <= grant_idx;
                        cnt    <= CNT_W'(LAT - 1);
                        rr_ptr <= next_ptr;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        data_q <= core_p;
                        state  <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready = (state == IDLE) ? grant : '0;
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign rsp_id    = id_q;
    assign rsp_data  = data_q;

endmodule
